// File: rtl/ena_scheduler.sv
// Round-robin one-hot0 gate-enable scheduler with starvation override and quiescence detection.
// Optional: define ENA_SCHED_STALL_EN to add LFSR-driven random stalls between firings.
module ena_scheduler #(
  parameter int unsigned N            = 4,
  parameter int unsigned MAX_WAIT     = 7,
  parameter int unsigned QUIET_CYCLES = 3,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         run,
  input  logic [N-1:0] excited,
  output logic [N-1:0] ena,
  output logic         fired,
  output logic         quiescent,
  output logic         starve_err
);

  localparam int unsigned IdxW   = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned WaitW  = $clog2(MAX_WAIT + 1);
  localparam int unsigned QuietW = $clog2(QUIET_CYCLES + 1);
  localparam logic [WaitW-1:0]  WaitMax  = WaitW'(MAX_WAIT);
  localparam logic [QuietW-1:0] QuietMax = QuietW'(QUIET_CYCLES);

  if (LFSR_SEED == 16'h0) begin : g_seed_check
    $error("LFSR_SEED must be non-zero");
  end

  typedef enum logic [1:0] {StIdle, StScan, StFire, StSettle} state_e;

  state_e            state_q;
  logic [IdxW-1:0]   ptr_q;
  logic [WaitW-1:0]  wait_q [N];
  logic [QuietW-1:0] quiet_q;

  logic              any_exc, urgent_any, grant, starve_hit, withhold;
  logic [IdxW-1:0]   urgent_idx, rr_idx, winner, ptr_next;
  logic [N-1:0]      win_onehot;
  logic [WaitW-1:0]  wait_d   [N];
  logic [WaitW-1:0]  wait_inc [N];
  logic [QuietW-1:0] quiet_scan;

  assign any_exc = |excited;

  // Downward walk leaves the lowest-index urgent gate as the final assignment.
  always_comb begin
    urgent_any = 1'b0;
    urgent_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (excited[i] && (wait_q[i] == WaitMax)) begin
        urgent_any = 1'b1;
        urgent_idx = IdxW'(i);
      end
    end
  end

  always_comb begin
    rr_idx = ptr_q;
    for (int k = N - 1; k >= 0; k--) begin
      if (excited[(int'(ptr_q) + k) % N]) rr_idx = IdxW'((int'(ptr_q) + k) % N);
    end
  end

`ifdef ENA_SCHED_STALL_EN
  logic [15:0] lfsr_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end
  end

  // Urgent gates are never held back, so the stall cannot cause starvation.
  assign withhold = ~lfsr_q[0] & ~urgent_any;
`else
  assign withhold = 1'b0;
`endif

  assign winner     = urgent_any ? urgent_idx : rr_idx;
  assign grant      = run & any_exc & ~withhold;
  assign ptr_next   = IdxW'((int'(winner) + 1) % N);
  assign quiet_scan = any_exc ? '0 : ((quiet_q == QuietMax) ? quiet_q : quiet_q + 1'b1);

  always_comb begin
    win_onehot         = '0;
    win_onehot[winner] = 1'b1;
    starve_hit         = 1'b0;
    for (int i = 0; i < N; i++) begin
      wait_inc[i] = (wait_q[i] == WaitMax) ? wait_q[i] : wait_q[i] + 1'b1;
      wait_d[i]   = '0;
      if (excited[i] && (IdxW'(i) != winner)) begin
        wait_d[i] = wait_inc[i];
        if (wait_q[i] == WaitMax) starve_hit = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      ena        <= '0;
      fired      <= 1'b0;
      quiescent  <= 1'b0;
      starve_err <= 1'b0;
      ptr_q      <= '0;
      quiet_q    <= '0;
      for (int i = 0; i < N; i++) wait_q[i] <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          quiet_q   <= '0;
          quiescent <= 1'b0;
          if (run) state_q <= StScan;
        end
        StScan: begin
          quiet_q   <= quiet_scan;
          quiescent <= (quiet_scan == QuietMax);
          if (!run) begin
            state_q <= StIdle;
          end else if (grant) begin
            state_q <= StFire;
            ena     <= win_onehot;
            fired   <= 1'b1;
            ptr_q   <= ptr_next;
            wait_q  <= wait_d;
            if (starve_hit) starve_err <= 1'b1;
          end
`ifdef ENA_SCHED_STALL_EN
          else if (any_exc) begin
            for (int i = 0; i < N; i++) begin
              if (excited[i]) wait_q[i] <= wait_inc[i];
            end
          end
`endif
        end
        StFire: begin
          ena     <= '0;
          fired   <= 1'b0;
          state_q <= StSettle;
        end
        StSettle: begin
          state_q <= run ? StScan : StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_ena_scheduler.sv
// Bench for ena_scheduler: two instances (MAX_WAIT 7 and 2) checked every cycle against an
// integer reference model, plus directed literal expectations.
module tb_ena_scheduler;
  localparam int N     = 4;
  localparam int QUIET = 3;

  logic         clk     = 1'b0;
  logic         reset_n = 1'b0;
  logic         run     = 1'b0;
  logic [N-1:0] excited = '0;
  logic [N-1:0] ena0, ena1;
  logic         fired0, fired1, quiet0, quiet1, starve0, starve1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ena_scheduler #(.N(N), .MAX_WAIT(7), .QUIET_CYCLES(QUIET), .LFSR_SEED(16'hACE1)) dut (
    .clk(clk), .reset_n(reset_n), .run(run), .excited(excited),
    .ena(ena0), .fired(fired0), .quiescent(quiet0), .starve_err(starve0)
  );

  ena_scheduler #(.N(N), .MAX_WAIT(2), .QUIET_CYCLES(QUIET), .LFSR_SEED(16'hACE1)) dut_u (
    .clk(clk), .reset_n(reset_n), .run(run), .excited(excited),
    .ena(ena1), .fired(fired1), .quiescent(quiet1), .starve_err(starve1)
  );

  // Reference model: busy counts remaining fire/settle cycles after a grant.
  int           max_wait [2] = '{7, 2};
  int           m_ptr    [2];
  int           m_wait   [2][N];
  int           m_quiet  [2];
  bit           m_starve [2];
  bit           m_active [2];
  int           m_busy   [2];
  logic [N-1:0] m_ena    [2];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_ptr[k] = 0; m_quiet[k] = 0; m_starve[k] = 0;
      m_active[k] = 0; m_busy[k] = 0; m_ena[k] = '0;
      for (int i = 0; i < N; i++) m_wait[k][i] = 0;
    end
  endtask

  task automatic model_step(input int k);
    int w;
    int j;
    if (m_busy[k] == 2) begin
      m_ena[k]  = '0;
      m_busy[k] = 1;
    end else if (m_busy[k] == 1) begin
      m_busy[k]   = 0;
      m_active[k] = run;
    end else if (!m_active[k]) begin
      m_quiet[k]  = 0;
      m_active[k] = run;
    end else begin
      if (excited == '0) m_quiet[k] = (m_quiet[k] < QUIET) ? m_quiet[k] + 1 : QUIET;
      else m_quiet[k] = 0;
      if (!run) begin
        m_active[k] = 0;
      end else if (excited != '0) begin
        w = -1;
        for (int i = 0; i < N; i++)
          if (w < 0 && excited[i] && m_wait[k][i] == max_wait[k]) w = i;
        for (int s = 0; s < N; s++) begin
          j = (m_ptr[k] + s) % N;
          if (w < 0 && excited[j]) w = j;
        end
        for (int i = 0; i < N; i++) begin
          if (excited[i] && i != w && m_wait[k][i] == max_wait[k]) m_starve[k] = 1;
          if (!excited[i] || i == w) m_wait[k][i] = 0;
          else if (m_wait[k][i] < max_wait[k]) m_wait[k][i] = m_wait[k][i] + 1;
        end
        m_ptr[k]    = (w + 1) % N;
        m_ena[k]    = '0;
        m_ena[k][w] = 1'b1;
        m_busy[k]   = 2;
      end
    end
  endtask

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) model_reset();
    else for (int k = 0; k < 2; k++) model_step(k);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    check("model_ena0",    32'(ena0),    32'(m_ena[0]));
    check("model_fired0",  32'(fired0),  32'(|m_ena[0]));
    check("model_quiet0",  32'(quiet0),  32'(m_quiet[0] == QUIET));
    check("model_starve0", 32'(starve0), 32'(m_starve[0]));
    check("model_ena1",    32'(ena1),    32'(m_ena[1]));
    check("model_fired1",  32'(fired1),  32'(|m_ena[1]));
    check("model_quiet1",  32'(quiet1),  32'(m_quiet[1] == QUIET));
    check("model_starve1", 32'(starve1), 32'(m_starve[1]));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (reset_n) compare_model();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    run     = 1'b0;
    excited = '0;
    repeat (2) tick();
    reset_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, n_fail %0d", n_fail);
    $fatal(1);
  end

  logic [3:0] rr_exp [15];
  logic [3:0] ws_exp [14];
  logic [3:0] u0_exp [8];
  logic [3:0] u1_exp [8];

  initial begin
    rr_exp = '{4'h0, 4'h1, 4'h0, 4'h0, 4'h2, 4'h0, 4'h0, 4'h4, 4'h0, 4'h0, 4'h8, 4'h0, 4'h0,
               4'h1, 4'h0};
    ws_exp = '{4'h0, 4'h1, 4'h0, 4'h0, 4'h2, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h2, 4'h0, 4'h0,
               4'h4};
    u0_exp = '{4'h0, 4'h1, 4'h0, 4'h0, 4'h2, 4'h0, 4'h0, 4'h4};
    u1_exp = '{4'h0, 4'h1, 4'h0, 4'h0, 4'h2, 4'h0, 4'h0, 4'h8};

    // Reset then idle with run low.
    do_reset();
    excited = 4'b1111;
    for (int t = 0; t < 10; t++) begin
      tick();
      check("idle_ena",   32'(ena0),   32'd0);
      check("idle_fired", 32'(fired0), 32'd0);
      check("idle_quiet", 32'(quiet0), 32'd0);
    end

    // Round-robin over all gates.
    do_reset();
    excited = 4'b1111;
    run     = 1'b1;
    for (int t = 0; t < 15; t++) begin
      tick();
      check("rr_ena",   32'(ena0),   32'(rr_exp[t]));
      check("rr_fired", 32'(fired0), 32'(|rr_exp[t]));
    end
    check("rr_starve0", 32'(starve0), 32'd0);
    check("rr_starve1", 32'(starve1), 32'd1);

    // Wrap and skip: pointer reaches 2, then 0011 wraps to gate 0; 1111 then proves pointer=2.
    do_reset();
    excited = 4'b0011;
    run     = 1'b1;
    for (int t = 0; t < 14; t++) begin
      tick();
      check("wrap_ena", 32'(ena0), 32'(ws_exp[t]));
      if (t == 10) excited = 4'b1111;
    end

    // Urgency: gate 3 overrides round-robin only in the MAX_WAIT=2 instance.
    do_reset();
    excited = 4'b1011;
    run     = 1'b1;
    for (int t = 0; t < 8; t++) begin
      tick();
      check("urg_ena0", 32'(ena0), 32'(u0_exp[t]));
      check("urg_ena1", 32'(ena1), 32'(u1_exp[t]));
      if (t == 4) excited = 4'b1111;
    end
    check("urg_starve0", 32'(starve0), 32'd0);
    check("urg_starve1", 32'(starve1), 32'd0);

    // Quiescence, then run dropped during FIRE.
    do_reset();
    run = 1'b1;
    for (int t = 1; t <= 4; t++) begin
      tick();
      check("quiet_level", 32'(quiet0), 32'(t == 4));
    end
    excited = 4'b0100;
    tick();
    check("quiet_clear", 32'(quiet0), 32'd0);
    check("quiet_ena",   32'(ena0),   32'h4);
    check("quiet_fired", 32'(fired0), 32'd1);
    run     = 1'b0;
    excited = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      tick();
      check("rundrop_ena", 32'(ena0), 32'd0);
    end
    run = 1'b1;
    tick();
    tick();
    check("resume_ena0", 32'(ena0), 32'h8);
    check("resume_ena1", 32'(ena1), 32'h8);

    // Asynchronous reset while a gate is enabled.
    do_reset();
    excited = 4'b0100;
    run     = 1'b1;
    tick();
    tick();
    check("arst_pre_ena", 32'(ena0), 32'h4);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_ena0",  32'(ena0),   32'd0);
    check("arst_fired", 32'(fired0), 32'd0);
    check("arst_ena1",  32'(ena1),   32'd0);
    #3;
    reset_n = 1'b1;
    excited = 4'b1111;
    run     = 1'b1;
    tick();
    tick();
    check("arst_ptr_ena", 32'(ena0), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
